mac_operand_zip: RTL
====================

Name: mac_operand_zip

Overview:
- Upstream feeder for the 16-bit mac unit.
- Takes independent operand-A and operand-B val/rdy streams, buffers each, and zips them into {a,b} 32-bit request messages.
- Tracks position within the mac's 4-beat accumulation group.
- On request, pads a partial group with zero pairs so the mac always completes a group; zero pairs add nothing to the sum.

Parameters:
- p_width, 16: operand width; out_msg is 2*p_width.
- p_group, 4: beats per mac accumulation group; must be a power of 2, >= 2.
- p_depth, 2: entries per operand FIFO; must be >= 1.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- a_val, input, 1: operand-A valid.
- a_rdy, output, 1: operand-A ready.
- a_msg, input, p_width: operand A.
- b_val, input, 1: operand-B valid.
- b_rdy, output, 1: operand-B ready.
- b_msg, input, p_width: operand B.
- flush_val, input, 1: request to pad the current partial group.
- flush_rdy, output, 1: flush accept.
- out_val, output, 1: pair valid to mac req_val.
- out_rdy, input, 1: from mac req_rdy.
- out_msg, output, 2*p_width: {a,b} to mac req_msg.
- grp_idx, output, clog2(p_group): beat index of the current out_msg within its group.
- busy, output, 1: any buffered operand, partial group, or padding in progress.

Behaviour:
- Reset (reset_n low, asynchronous): FIFOs empty, beat counter 0, state STREAM.
  - Outputs: out_val=0, out_msg=0, grp_idx=0, busy=0, flush_rdy=1.
  - a_rdy and b_rdy read 1 but no enqueue occurs while reset_n=0.
  - Reset mid-operation discards buffered operands and any partial group immediately.
- Operand FIFOs:
  - a_rdy = !a_full and b_rdy = !b_full, both registered-state derived; no combinational path from out_rdy.
  - Enqueue on val&&rdy. No bypass: an operand accepted in cycle N can appear on out_msg no earlier than cycle N+1.
  - Simultaneous enqueue and dequeue on a full FIFO is not allowed (rdy is already 0).
  - Simultaneous enqueue and dequeue on a non-full FIFO keeps occupancy unchanged.
- Output:
  - out_msg = 0 whenever out_val=0.
  - A fire is out_val && out_rdy.
  - Each fire advances the beat counter modulo p_group; a wrap from p_group-1 to 0 closes the group.
  - grp_idx always equals the beat counter.
  - out_val/out_msg stay stable while out_rdy=0.
- FSM states:
  - STREAM:
    - out_val = !a_empty && !b_empty; out_msg = {a_head, b_head}; a fire pops both FIFOs.
    - flush_rdy=1.
    - On flush_val && flush_rdy, the beat counter value after this cycle's fire is evaluated: 0 → flush is a no-op, stay in STREAM; nonzero → go to PAD.
  - PAD:
    - out_val=1, out_msg=0, FIFOs not popped, flush_rdy=0.
    - Each fire advances the counter; a fire that wraps it to 0 returns to STREAM.
    - Operand enqueues continue normally during PAD.
- busy = (state==PAD) || !a_empty || !b_empty || (beat counter != 0).
- Arithmetic: the beat counter is clog2(p_group) bits with natural wrap. FIFO pointers wrap modulo p_depth. Occupancy is a clog2(p_depth+1)-bit count.

Decomposition:
- mac_pkg holds:
  - default operand width (16) and MAC_GROUP (4);
  - the FSM state enum {STREAM, PAD};
  - a pair typedef struct {a,b} of width 2*p_width.
- One sub-module: mac_operand_fifo (parameterised p_width/p_depth val/rdy FIFO with full/empty flags), instantiated twice for A and B.

Test Plan:
- Reset, no stimulus: hold reset_n low 2 cycles, release mid-period → out_val=0, out_msg=0, grp_idx=0, busy=0, flush_rdy=1.
- Full group:
  - Stimulus: A=5,2,4,2 and B=10,4,8,1 presented together, out_rdy=1.
  - Required: out_msg=0x0005000A, 0x00020004, 0x00040008, 0x00020001 on consecutive cycles starting 1 cycle after first accept; grp_idx=0,1,2,3; counter back to 0; mac downstream returns 92.
- Stream skew:
  - Stimulus: A sends 7,9; B idle 5 cycles, then sends 3,3.
  - Required: a_rdy=0 after the two A accepts (p_depth=2); out_val=0 until B's first item is buffered; then out_msg=0x00070003 followed by 0x00090003.
- Flush:
  - Stimulus: 2 pairs (10,10), (8,8), then flush_val=1.
  - Required: state goes to PAD; 2 beats of out_msg=0 with grp_idx=2,3; flush_rdy=0 during PAD; then STREAM, grp_idx=0; mac returns 164.
  - Also: a flush with grp_idx=0 → no out_val pulse.
- Backpressure: with a pair pending, drop out_rdy for 3 cycles → out_msg held stable, FIFOs fill, a_rdy and b_rdy drop to 0, no beat lost or duplicated once out_rdy=1.
- Async reset mid-PAD:
  - Stimulus: assert reset_n low between clock edges while in PAD at grp_idx=2.
  - Required: out_val=0 immediately (before the next edge); after release, grp_idx=0, busy=0, state STREAM.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and defaults for the mac operand zipper.
package mac_pkg;

  localparam int MAC_WIDTH = 16;
  localparam int MAC_GROUP = 4;

  typedef enum logic {
    STREAM = 1'b0,
    PAD    = 1'b1
  } zip_state_e;

  typedef struct packed {
    logic [MAC_WIDTH-1:0] a;
    logic [MAC_WIDTH-1:0] b;
  } mac_pair_t;

endpackage

// File: rtl/mac_operand_fifo.sv
// Small val/rdy operand FIFO; ready is derived only from stored occupancy.
module mac_operand_fifo
  import mac_pkg::*;
#(
  parameter int p_width = MAC_WIDTH,
  parameter int p_depth = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enq_val,
  output logic               enq_rdy,
  input  logic [p_width-1:0] enq_msg,
  input  logic               deq,
  output logic [p_width-1:0] head,
  output logic               full,
  output logic               empty
);

  localparam int PW = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int CW = $clog2(p_depth + 1);

  logic [p_depth-1:0][p_width-1:0] mem;
  logic [PW-1:0]                   wr_ptr, rd_ptr;
  logic [CW-1:0]                   count;
  logic                            enq, deq_ok;

  function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
    return (p == PW'(p_depth - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(p_depth));
  assign empty   = (count == '0);
  assign enq_rdy = !full;
  assign enq     = enq_val && enq_rdy;
  assign deq_ok  = deq && !empty;
  assign head    = mem[rd_ptr];

  // Storage is not reset: every read of head is qualified by !empty.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= enq_msg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq)    wr_ptr <= ptr_nxt(wr_ptr);
      if (deq_ok) rd_ptr <= ptr_nxt(rd_ptr);
      case ({enq, deq_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mac_operand_zip.sv
// Zips buffered A/B operand streams into {a,b} mac requests, padding partial groups on flush.
module mac_operand_zip
  import mac_pkg::*;
#(
  parameter int p_width = MAC_WIDTH,
  parameter int p_group = MAC_GROUP,
  parameter int p_depth = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       a_val,
  output logic                       a_rdy,
  input  logic [p_width-1:0]         a_msg,
  input  logic                       b_val,
  output logic                       b_rdy,
  input  logic [p_width-1:0]         b_msg,
  input  logic                       flush_val,
  output logic                       flush_rdy,
  output logic                       out_val,
  input  logic                       out_rdy,
  output logic [2*p_width-1:0]       out_msg,
  output logic [$clog2(p_group)-1:0] grp_idx,
  output logic                       busy
);

  localparam int GW = $clog2(p_group);

  zip_state_e     state;
  logic [GW-1:0]  cnt, cnt_nxt;
  logic [p_width-1:0] a_head, b_head;
  logic           a_full, a_empty, b_full, b_empty;
  logic           fire, pop;

  mac_operand_fifo #(.p_width(p_width), .p_depth(p_depth)) u_fifo_a (
    .clk(clk), .reset_n(reset_n),
    .enq_val(a_val), .enq_rdy(a_rdy), .enq_msg(a_msg),
    .deq(pop), .head(a_head), .full(a_full), .empty(a_empty)
  );

  mac_operand_fifo #(.p_width(p_width), .p_depth(p_depth)) u_fifo_b (
    .clk(clk), .reset_n(reset_n),
    .enq_val(b_val), .enq_rdy(b_rdy), .enq_msg(b_msg),
    .deq(pop), .head(b_head), .full(b_full), .empty(b_empty)
  );

  // Outputs depend only on registered state, so async reset clears them at once.
  always_comb begin
    out_val = 1'b0;
    out_msg = '0;
    if (state == PAD) begin
      out_val = 1'b1;
    end else if (!a_empty && !b_empty) begin
      out_val = 1'b1;
      out_msg = {a_head, b_head};
    end
  end

  assign fire      = out_val && out_rdy;
  assign pop       = fire && (state == STREAM);
  assign cnt_nxt   = fire ? cnt + GW'(1) : cnt;
  assign flush_rdy = (state == STREAM);
  assign grp_idx   = cnt;
  assign busy      = (state == PAD) || !a_empty || !b_empty || (cnt != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= STREAM;
      cnt   <= '0;
    end else begin
      cnt <= cnt_nxt;
      case (state)
        STREAM:  if (flush_val && cnt_nxt != '0) state <= PAD;
        PAD:     if (fire && cnt_nxt == '0) state <= STREAM;
        default: state <= STREAM;
      endcase
    end
  end

endmodule
